// File: rtl/win_trig_counter_pkg.sv
// Shared types and defaults for the capture window counter.
// The state labels are imported by the top level and the limit counter.
package win_trig_pkg;

  localparam int DEF_CNT_W = 18;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic is_busy(state_e s);
    return (s == ST_PRE) || (s == ST_ARMED) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/win_trig_counter_if.sv
// Control, limit and status bundle between the trigger logic and the window counter.
// The master side drives commands and limits; the slave side reports count and flags.
interface win_trig_counter_if
  import win_trig_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             START;
  logic             ABORT;
  logic             CNT_EN;
  logic             LA_RLE_CNT_EN;
  logic             TRIG;
  logic [CNT_W-1:0] PRE_DATA;
  logic [CNT_W-1:0] POST_DATA;
  logic [CNT_W-1:0] WINcnt;
  logic             Pre_Full;
  logic             Trig_Seen;
  logic             Write_Ready;
  logic             Busy;

  modport master (
    output START, ABORT, CNT_EN, LA_RLE_CNT_EN, TRIG, PRE_DATA, POST_DATA,
    input  WINcnt, Pre_Full, Trig_Seen, Write_Ready, Busy
  );

  modport slave (
    input  START, ABORT, CNT_EN, LA_RLE_CNT_EN, TRIG, PRE_DATA, POST_DATA,
    output WINcnt, Pre_Full, Trig_Seen, Write_Ready, Busy
  );

endinterface

// File: rtl/win_trig_counter_limit.sv
// Equality counter shared by the PRE and POST phases.
// hit_o compares before incrementing, so a full-scale limit never wraps.
module win_limit_counter
  import win_trig_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] lim_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             hit_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign hit_o = (cnt_q == lim_i);
  assign cnt_o = cnt_q;

  // NOTE: cnt_d gets its hold value first so every path assigns it and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !hit_o) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/win_trig_counter.sv
// Capture window sequencer: PRE fill, ARMED wait for trigger, POST fill, then DONE.
// Strobes are registered once before counting; limits are frozen at the start of each run.
module win_trig_counter
  import win_trig_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter bit AUTO_REARM = 1'b0
) (
  input logic CLK,
  input logic RST,
  win_trig_counter_if.slave bus
);

  state_e           state_q;
  logic             stb_d, stb_q;
  logic [CNT_W-1:0] pre_lim_q, post_lim_q, lim_sel, cnt;
  logic             pre_full_q, trig_seen_q, wr_ready_q;
  logic             start_ok, rearm, phase_end, hit, cnt_clr, cnt_en;

  assign stb_d     = bus.CNT_EN & bus.LA_RLE_CNT_EN;
  assign start_ok  = bus.START & ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign rearm     = AUTO_REARM && (state_q == ST_DONE);
  assign phase_end = stb_q & hit;
  assign lim_sel   = (state_q == ST_POST) ? post_lim_q : pre_lim_q;
  assign cnt_en    = stb_q & ((state_q == ST_PRE) || (state_q == ST_POST));

  // The count is zero whenever no phase is running and restarts on trigger and POST completion.
  assign cnt_clr = bus.ABORT
                 | (state_q == ST_IDLE)
                 | (state_q == ST_DONE)
                 | ((state_q == ST_ARMED) & bus.TRIG)
                 | ((state_q == ST_POST) & phase_end);

  win_limit_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .lim_i (lim_sel),
    .cnt_o (cnt),
    .hit_o (hit)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      stb_q       <= 1'b0;
      pre_lim_q   <= '0;
      post_lim_q  <= '0;
      pre_full_q  <= 1'b0;
      trig_seen_q <= 1'b0;
      wr_ready_q  <= 1'b0;
    end else begin
      stb_q <= stb_d;
      if (bus.ABORT) begin
        state_q     <= ST_IDLE;
        pre_full_q  <= 1'b0;
        trig_seen_q <= 1'b0;
        wr_ready_q  <= 1'b0;
      end else if (start_ok || rearm) begin
        state_q     <= ST_PRE;
        pre_lim_q   <= bus.PRE_DATA;
        post_lim_q  <= bus.POST_DATA;
        pre_full_q  <= 1'b0;
        trig_seen_q <= 1'b0;
        wr_ready_q  <= 1'b0;
      end else begin
        case (state_q)
          // A trigger coinciding with the final PRE strobe is dropped on purpose.
          ST_PRE: if (phase_end) begin
            pre_full_q <= 1'b1;
            state_q    <= ST_ARMED;
          end
          ST_ARMED: if (bus.TRIG) begin
            trig_seen_q <= 1'b1;
            state_q     <= ST_POST;
          end
          ST_POST: if (phase_end) begin
            wr_ready_q <= 1'b1;
            state_q    <= ST_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.WINcnt      = cnt;
  assign bus.Pre_Full    = pre_full_q;
  assign bus.Trig_Seen   = trig_seen_q;
  assign bus.Write_Ready = wr_ready_q;
  assign bus.Busy        = is_busy(state_q);

endmodule

// File: tb/tb_win_trig_counter.sv
// Bench for win_trig_counter: a one-shot 18-bit instance and an auto-rearm 4-bit instance
// share stimulus and are compared every cycle against a strobe-counting reference model.
module tb_win_trig_counter;

  localparam int WA = 18;
  localparam int WB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic          cnt_en = 1'b0, rle = 1'b0, trig = 1'b0;
  logic [WA-1:0] pre_data = '0, post_data = '0;

  win_trig_counter_if #(.CNT_W(WA)) if_a ();
  win_trig_counter_if #(.CNT_W(WB)) if_b ();

  assign if_a.START = start;          assign if_b.START = start;
  assign if_a.ABORT = abort;          assign if_b.ABORT = abort;
  assign if_a.CNT_EN = cnt_en;        assign if_b.CNT_EN = cnt_en;
  assign if_a.LA_RLE_CNT_EN = rle;    assign if_b.LA_RLE_CNT_EN = rle;
  assign if_a.TRIG = trig;            assign if_b.TRIG = trig;
  assign if_a.PRE_DATA = pre_data;    assign if_b.PRE_DATA = pre_data[WB-1:0];
  assign if_a.POST_DATA = post_data;  assign if_b.POST_DATA = post_data[WB-1:0];

  win_trig_counter #(.CNT_W(WA), .AUTO_REARM(1'b0)) dut_a (.CLK(clk), .RST(rst), .bus(if_a));
  win_trig_counter #(.CNT_W(WB), .AUTO_REARM(1'b1)) dut_b (.CLK(clk), .RST(rst), .bus(if_b));

  // Reference model: tracks how many strobes each phase has consumed.
  typedef enum {M_IDLE, M_PRE, M_ARMED, M_POST, M_DONE} phase_e;
  phase_e m_phase[2];
  longint m_seen[2], m_pre[2], m_post[2];
  bit     m_pf[2], m_ts[2], m_wr[2];
  bit     m_stb;
  longint mask[2] = '{(longint'(1) << WA) - 1, (longint'(1) << WB) - 1};
  bit     auto_mode[2] = '{1'b0, 1'b1};

  int errors = 0;
  int checks = 0;

  function automatic void model_step();
    bit s = m_stb;
    m_stb = rst ? 1'b0 : (cnt_en & rle);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_phase[d] = M_IDLE; m_seen[d] = 0; m_pre[d] = 0; m_post[d] = 0;
        m_pf[d] = 0; m_ts[d] = 0; m_wr[d] = 0;
      end else if (abort) begin
        m_phase[d] = M_IDLE; m_seen[d] = 0; m_pf[d] = 0; m_ts[d] = 0; m_wr[d] = 0;
      end else if ((start && (m_phase[d] == M_IDLE || m_phase[d] == M_DONE)) ||
                   (auto_mode[d] && m_phase[d] == M_DONE)) begin
        m_pre[d]  = longint'(pre_data) & mask[d];
        m_post[d] = longint'(post_data) & mask[d];
        m_phase[d] = M_PRE; m_seen[d] = 0; m_pf[d] = 0; m_ts[d] = 0; m_wr[d] = 0;
      end else begin
        case (m_phase[d])
          M_PRE: if (s) begin
            m_seen[d]++;
            if (m_seen[d] == m_pre[d] + 1) begin m_pf[d] = 1; m_phase[d] = M_ARMED; end
          end
          M_ARMED: if (trig) begin m_phase[d] = M_POST; m_seen[d] = 0; m_ts[d] = 1; end
          M_POST: if (s) begin
            m_seen[d]++;
            if (m_seen[d] == m_post[d] + 1) begin m_wr[d] = 1; m_phase[d] = M_DONE; m_seen[d] = 0; end
          end
          default: ;
        endcase
      end
    end
  endfunction

  function automatic logic [WA+3:0] exp_vec(int d);
    longint c;
    logic   busy;
    case (m_phase[d])
      M_PRE, M_POST: c = m_seen[d];
      M_ARMED:       c = m_pre[d];
      default:       c = 0;
    endcase
    busy = (m_phase[d] == M_PRE) || (m_phase[d] == M_ARMED) || (m_phase[d] == M_POST);
    return {c[WA-1:0], m_pf[d], m_ts[d], m_wr[d], busy};
  endfunction

  function automatic logic [WA+3:0] act_vec(int d);
    if (d == 0) return {if_a.WINcnt, if_a.Pre_Full, if_a.Trig_Seen, if_a.Write_Ready, if_a.Busy};
    return {{(WA-WB){1'b0}}, if_b.WINcnt, if_b.Pre_Full, if_b.Trig_Seen, if_b.Write_Ready, if_b.Busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic begin_run(input int pre, input int post);
    abort = 1'b1; start = 1'b0; trig = 1'b0;
    tick();
    abort = 1'b0; start = 1'b1;
    pre_data = WA'(pre); post_data = WA'(post);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL reset dut%0d t=%0t: got %h expected %h", d, $time, act_vec(d), exp_vec(d));
        end
      end
      if (c == 1) rst = 1'b0;
    end
  endtask

  task automatic test_basic();
    int t_pf = -1;
    begin_run(3, 4);
    cnt_en = 1'b1; rle = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL basic dut%0d t=%0t: got %h expected %h", d, $time, act_vec(d), exp_vec(d));
        end
      end
      start = 1'b0;
      if (t_pf < 0 && m_pf[0]) t_pf = c;
      trig = (t_pf >= 0) && (c == t_pf + 10);
    end
    checks++;
    if (if_a.Write_Ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_hold: Write_Ready got %b expected 1", if_a.Write_Ready);
    end
  endtask

  task automatic test_reset_mid_post();
    int post_c = -1;
    begin_run(3, 5);
    cnt_en = 1'b1; rle = 1'b1; trig = 1'b1;
    for (int c = 0; c < 40 && post_c < 0; c++) begin
      tick();
      start = 1'b0;
      if (m_phase[0] == M_POST) post_c = c;
    end
    checks++;
    if (post_c < 0) begin
      errors++;
      $display("FAIL mid_post_timeout: never reached POST");
    end
    trig = 1'b0;
    tick(); tick();
    rst = 1'b1;
    for (int c = 0; c < 24; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL mid_post_reset dut%0d t=%0t: got %h expected %h", d, $time, act_vec(d), exp_vec(d));
        end
      end
      rst = (c < 1);
      start = (c == 2);
      pre_data = WA'(1); post_data = WA'(1);
      trig = (c == 10);
    end
  endtask

  task automatic test_qualifier();
    begin_run(2, 1);
    cnt_en = 1'b1; rle = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL qualifier dut%0d t=%0t: got %h expected %h", d, $time, act_vec(d), exp_vec(d));
        end
      end
      start = 1'b0;
      rle = ~rle;
    end
  endtask

  task automatic test_zero_limits();
    begin_run(0, 0);
    rle = 1'b1; cnt_en = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL zero_limits dut%0d t=%0t: got %h expected %h", d, $time, act_vec(d), exp_vec(d));
        end
      end
      start = 1'b0;
      cnt_en = (c == 1) || (c == 8);
      trig = (c == 5);
    end
    checks++;
    if (if_a.Write_Ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_limits_done: Write_Ready got %b expected 1", if_a.Write_Ready);
    end
  endtask

  task automatic test_trig_in_pre();
    int armed_at = -1;
    begin_run(2, 1);
    cnt_en = 1'b1; rle = 1'b1; trig = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL trig_in_pre dut%0d t=%0t: got %h expected %h", d, $time, act_vec(d), exp_vec(d));
        end
      end
      start = 1'b0;
      if (armed_at < 0 && m_phase[0] == M_ARMED) armed_at = c;
      if (armed_at >= 0 && c == armed_at + 3) begin
        checks++;
        if (if_a.Trig_Seen !== 1'b0 || if_a.Busy !== 1'b1) begin
          errors++;
          $display("FAIL trig_in_pre_armed: Trig_Seen=%b Busy=%b expected 0 1", if_a.Trig_Seen, if_a.Busy);
        end
      end
      trig = (m_phase[0] == M_PRE) || ((armed_at >= 0) && (c == armed_at + 5));
    end
  endtask

  task automatic test_auto_rearm();
    int run_len = 0, run_max = 0, armed_c = -1;
    begin_run(1, 1);
    cnt_en = 1'b1; rle = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL auto_rearm dut%0d t=%0t: got %h expected %h", d, $time, act_vec(d), exp_vec(d));
        end
      end
      run_len = if_b.Write_Ready ? run_len + 1 : 0;
      if (run_len > run_max) run_max = run_len;
      start = 1'b0;
      trig = (c % 9 == 8);
    end
    checks++;
    if (run_max !== 1) begin
      errors++;
      $display("FAIL auto_pulse_width: longest Write_Ready run %0d expected 1", run_max);
    end
    begin_run(1, 1);
    trig = 1'b0;
    for (int c = 0; c < 20 && armed_c < 0; c++) begin
      tick();
      start = 1'b0;
      if (m_phase[1] == M_ARMED) armed_c = c;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (armed_c < 0 || if_b.Busy !== 1'b0 || act_vec(1) !== exp_vec(1)) begin
      errors++;
      $display("FAIL abort_armed: armed_at=%0d Busy=%b got %h expected %h", armed_c, if_b.Busy, act_vec(1), exp_vec(1));
    end
  endtask

  task automatic test_max_limit();
    logic [WB-1:0] max_b = '0;
    begin_run(15, 15);
    cnt_en = 1'b1; rle = 1'b1; trig = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL max_limit dut%0d t=%0t: got %h expected %h", d, $time, act_vec(d), exp_vec(d));
        end
      end
      if (if_b.WINcnt > max_b) max_b = if_b.WINcnt;
      start = 1'b0;
    end
    checks++;
    if (max_b !== 4'd15) begin
      errors++;
      $display("FAIL max_limit_peak: peak WINcnt %0d expected 15", max_b);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 499) == 0);
      abort  = ($urandom_range(0, 199) == 0);
      start  = ($urandom_range(0, 19) == 0);
      cnt_en = ($urandom_range(0, 3) != 0);
      rle    = ($urandom_range(0, 3) != 0);
      trig   = ($urandom_range(0, 9) == 0);
      pre_data  = ($urandom_range(0, 15) == 0) ? WA'(15) : WA'($urandom_range(0, 6));
      post_data = WA'($urandom_range(0, 6));
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL random dut%0d t=%0t: got %h expected %h", d, $time, act_vec(d), exp_vec(d));
        end
      end
    end
    rst = 1'b0; abort = 1'b0; start = 1'b0; trig = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_post();
    test_qualifier();
    test_zero_limits();
    test_trig_in_pre();
    test_auto_rearm();
    test_max_limit();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/win_trig_counter.md
Name: win_trig_counter

Overview:
Parametrised successor to the capture window counter. It sequences one capture window as a pre-trigger phase, then an armed wait, then a post-trigger phase. Each phase counts qualified sample strobes against its own limit, and the block flags Write_Ready when the post-trigger count completes. It sits between the trigger logic and the SRAM write-address generator in the LA/scope capture path, and supports one-shot and auto-rearm operation.

Parameters:
CNT_W, 18, width of the counter and of both limit inputs.
AUTO_REARM, 0, 0 means DONE holds until START or ABORT; 1 means DONE lasts one cycle and the block re-enters PRE.

Ports:
CLK  in  1  single system clock; all logic is on its rising edge.
RST  in  1  synchronous reset, active-high.
START  in  1  starts a capture from IDLE or DONE; latches both limits.
ABORT  in  1  forces a return to IDLE from any state.
CNT_EN  in  1  sample strobe from the sample-rate divider.
LA_RLE_CNT_EN  in  1  RLE qualifier; a strobe counts only when it is 1.
TRIG  in  1  trigger event, single-cycle or level.
PRE_DATA  in  CNT_W  pre-trigger limit.
POST_DATA  in  CNT_W  post-trigger limit.
WINcnt  out  CNT_W  current phase count.
Pre_Full  out  1  pre-trigger window is filled.
Trig_Seen  out  1  trigger has been accepted this capture.
Write_Ready  out  1  capture window is complete.
Busy  out  1  high while the state is PRE, ARMED or POST.

Behaviour:
- Reset: when RST=1 at a clock edge, state becomes IDLE. WINcnt, Pre_Full, Trig_Seen, Write_Ready, Busy, the strobe register and both limit registers all clear to 0. RST overrides every other input.
- Strobe pipeline: stb_q <= CNT_EN & LA_RLE_CNT_EN every cycle. Counting uses only stb_q, so a strobe takes effect one cycle after it is presented.
- Limits: pre_lim and post_lim are loaded from PRE_DATA and POST_DATA on an accepted START. Changes to the inputs during a run are ignored.
- Count rule for each phase: on stb_q=1, if WINcnt equals the phase limit, the phase ends; otherwise WINcnt increments by 1.
  - A limit of N therefore consumes N+1 strobes.
  - Equality is checked before incrementing, so a limit of 2^CNT_W-1 never wraps.
- States:
  - IDLE: WINcnt=0. START moves to PRE and clears Write_Ready, Pre_Full and Trig_Seen.
  - PRE: counts against pre_lim. When it ends, Pre_Full=1 and the state becomes ARMED. WINcnt holds at pre_lim. TRIG is ignored in PRE.
  - ARMED: WINcnt holds. TRIG=1 moves to POST in the same cycle: WINcnt<=0, Trig_Seen<=1. Strobes in ARMED are not counted; the write path keeps overwriting circularly.
  - POST: counts against post_lim. When it ends, WINcnt<=0, Write_Ready<=1, state<=DONE.
  - DONE with AUTO_REARM=0: Write_Ready stays 1. START clears it and the flags, reloads the limits and moves to PRE.
  - DONE with AUTO_REARM=1: the next cycle goes to PRE, clears Write_Ready, Pre_Full and Trig_Seen, and reloads the limits from the current inputs. Write_Ready is therefore a one-cycle pulse.
- Simultaneous events:
  - Priority order: RST, then ABORT, then START, then the state logic.
  - START in PRE, ARMED or POST is ignored.
  - TRIG together with the final PRE strobe: only the PRE-to-ARMED transition happens; the trigger is not captured and a later TRIG is required.
  - TRIG in POST or DONE is ignored.
- ABORT: moves to IDLE and clears WINcnt and all flags within one cycle.
- Busy is combinational from the state (PRE, ARMED or POST).

Decomposition:
- Package win_trig_pkg:
  - state encoding localparams ST_IDLE, ST_PRE, ST_ARMED, ST_POST, ST_DONE (3-bit);
  - default CNT_W.
- One natural sub-module, win_limit_counter, shared by the PRE and POST phases. It is a CNT_W equality counter with clear, enable and limit inputs and a "hit" output.
- The top level holds the state machine, the strobe register, the limit registers and the flags.

Test Plan:
- RST=1 for 2 cycles in mid-POST -> every output reads 0 and the state is IDLE on the next cycle; a following START gives a clean run.
- PRE_DATA=3, POST_DATA=4, START, continuous qualified strobes, TRIG 10 cycles after Pre_Full -> Pre_Full rises on the 4th counted strobe. WINcnt reads 0 after TRIG. Write_Ready rises on the 5th POST strobe and stays 1 with AUTO_REARM=0.
- LA_RLE_CNT_EN toggled 0/1 with CNT_EN=1, PRE_DATA=2 -> only qualified strobes count; Pre_Full rises 1 cycle after the 3rd qualified strobe.
- PRE_DATA=0 and POST_DATA=0 -> one strobe fills PRE; TRIG followed by one strobe completes the capture.
- TRIG held high during PRE and at the final PRE strobe, then deasserted -> stays ARMED with Trig_Seen=0; a new TRIG pulse moves to POST.
- AUTO_REARM=1, PRE_DATA=1, POST_DATA=1 -> Write_Ready is a single-cycle pulse, then Busy=1 in PRE with the flags cleared. ABORT mid-ARMED -> IDLE and Busy=0 next cycle.
